full_stage_ctrl_out_ctrl_p: RTL and testbench
=============================================

// Module: full_stage_ctrl_out_ctrl_p
// PURPOSE
//  Parametrised output/memory controller for one fully-connected stage. Drives the data, tap and bias RAM ports.
//  Runs the tap/bias feedback write-back delay line with a programmable latency.
//  Arbitrates feedback writes against error-update writes on the single tap write port; collided error writes are buffered.
//  Also adds a 2-entry vld/rdy skid buffer on the stage result, so downstream backpressure is honoured.
// PARAMETERS
//  DATA_W       32  width of one tap / data / bias word
//  NUM_TAPS     6   tap words per tap-RAM row (row width = NUM_TAPS*DATA_W)
//  TAP_AW       4   tap/bias RAM address width
//  DATA_AW      6   data RAM address width
//  PHASE_W      2   error phase width
//  ERR_BASE     12  first tap-RAM row holding error rows (ERR_BASE + 2**PHASE_W <= 2**TAP_AW)
//  FB_LAT       5   cycles from tap read to tap feedback write (>=2)
// PORTS
//  clk               in  1                clock
//  reset             in  1                asynchronous, active-low reset
//  active_normal     in  1                normal processing; enables RAM reads
//  active_start_d    in  1                first sample of a pass
//  data_valid        in  1                data RAM write strobe
//  data_value        in  DATA_W           data RAM write data
//  data_write_addr   in  DATA_AW          data RAM write address
//  data_read_addr    in  DATA_AW          data RAM read address
//  tap_address       in  TAP_AW           normal tap/bias read row
//  bias_wr_address   in  TAP_AW           bias write-back row
//  error_update_first in 1                select error row for read
//  error_update_latch in 1                tap row read for feedback update
//  error_phase       in  PHASE_W          error row for error writes
//  error_phase_read  in  PHASE_W          error row for error reads
//  error_valid       in  1                error sub-word write request
//  error_sub_address in  DATA_W           sub-word select for error write
//  error_value       in  DATA_W           error write data
//  tap_result        in  NUM_TAPS*DATA_W  updated tap row from datapath
//  bias_result       in  DATA_W           updated bias from datapath
//  stage_result      in  DATA_W           stage output sample
//  stage_result_vld  in  1                stage output sample valid
//  data_rd_vld/data_rd_addr/data_wr_vld/data_wr_addr/data_wr_data  out  1/DATA_AW/1/DATA_AW/DATA_W  data RAM port
//  tap_rd_vld/tap_rd_addr   out 1/TAP_AW  tap RAM read port
//  tap_wr_vld/tap_wr_addr/tap_wr_data  out 1/TAP_AW/NUM_TAPS*DATA_W  tap RAM write port
//  tap_sub_vld/tap_sub_addr/tap_sub_data  out 1/DATA_W/DATA_W  sub-word write qualifier
//  bias_rd_vld/bias_rd_addr/bias_wr_vld/bias_wr_addr/bias_wr_data  out  bias RAM port
//  error_rdy         out 1                error write accepted this cycle
//  out_data/out_vld  out DATA_W/1         stage output stream
//  out_rdy           in  1                downstream ready
//  first             out 1                = active_start_d
//  err_overflow      out 1                sticky: error write lost
//  out_overflow      out 1                sticky: output sample lost
// BEHAVIOUR
//  Reset (reset=0, async): delay line, pending buffer, skid buffer and sticky flags all clear.
//   All registered outputs are 0.
//  Data port (combinational passthrough):
//   data_wr_* = data_valid/data_write_addr/data_value; data_rd_vld=active_normal; data_rd_addr=data_read_addr.
//  Tap read (combinational):
//   tap_rd_addr = error_update_first ? ERR_BASE+error_phase_read : tap_address; tap_rd_vld=active_normal.
//   bias_rd_addr=tap_address; bias_rd_vld=active_normal.
//  Feedback delay line: FB_LAT stages of {fb_vld, tap_rd_addr}; fb_vld = error_update_latch & ~error_update_first.
//   Stage FB_LAT is the tap write-back (fbT); stage FB_LAT-1 is the bias write-back (fbB).
//  Bias write: bias_wr_vld=fbB.vld; bias_wr_addr=bias_wr_address; bias_wr_data=bias_result.
//  Tap write arbitration, priority fbT > pending > new error:
//   fbT.vld: wr_vld=1, addr=fbT.addr, data=tap_result, sub_vld=0.
//   else pending full: write the pending entry {ERR_BASE+phase, sub, value}, sub_vld=1; pending empties.
//   else error_valid: write {ERR_BASE+error_phase, error_sub_address, error_value}, sub_vld=1.
//   tap_wr_data=tap_result in every cycle; the sub-word is carried on tap_sub_data.
//  Error pending (1 entry): error_rdy = ~pending_full | pending drains this cycle.
//   error_valid & ~error_write_slot & ~pending_full -> capture into pending.
//   error_valid with no write slot and pending full (still blocked) -> drop, set err_overflow.
//  Output skid buffer (2-entry FIFO):
//   push on stage_result_vld; pop on out_vld&out_rdy; out_vld = ~empty; out_data = head (registered).
//   Push and pop in the same cycle with the FIFO full -> accepted, no loss.
//   Push when full without pop -> sample dropped, out_overflow=1.
//   Latency: first sample into an empty FIFO appears 1 cycle later.
//  Sticky flags clear only on reset.
//  Reset mid-operation discards in-flight feedback and buffered samples; there is no partial write afterwards.
// TESTING
//  1. tap_address=3, error_update_latch=1 for 1 cycle (defaults) -> tap_wr_vld=1, tap_wr_addr=3 exactly 5 cycles later.
//     bias_wr_vld=1 at 4 cycles, with bias_wr_address value.
//  2. error_update_first=1, error_phase_read=2 -> tap_rd_addr=14.
//     error_valid, error_phase=1, no feedback -> same-cycle tap_wr_addr=13, tap_sub_vld=1.
//  3. error_valid collides with fbT -> feedback row written, error written next cycle from pending, error_rdy=1 throughout.
//  4. Three consecutive collisions with back-to-back feedback -> err_overflow=1, error_rdy=0 while pending is blocked.
//  5. out_rdy=0, 3 samples (A,B,C) -> out_overflow=1, out_vld=1 holding A.
//     out_rdy=1 -> A then B delivered, C lost.
//  6. Assert reset=0 with feedback in flight and the FIFO non-empty -> all vld outputs 0 immediately.
//     No tap_wr_vld after release.

Source files
------------

// File: rtl/full_stage_ctrl_out_ctrl_p_if.sv
// Signal bundle for the fully-connected stage output/memory controller.
// slave = controller side, master = datapath/testbench side.
interface full_stage_ctrl_out_ctrl_p_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_TAPS = 6,
    parameter int TAP_AW   = 4,
    parameter int DATA_AW  = 6,
    parameter int PHASE_W  = 2
);
    logic                       active_normal;
    logic                       active_start_d;
    logic                       data_valid;
    logic [DATA_W-1:0]          data_value;
    logic [DATA_AW-1:0]         data_write_addr;
    logic [DATA_AW-1:0]         data_read_addr;
    logic [TAP_AW-1:0]          tap_address;
    logic [TAP_AW-1:0]          bias_wr_address;
    logic                       error_update_first;
    logic                       error_update_latch;
    logic [PHASE_W-1:0]         error_phase;
    logic [PHASE_W-1:0]         error_phase_read;
    logic                       error_valid;
    logic [DATA_W-1:0]          error_sub_address;
    logic [DATA_W-1:0]          error_value;
    logic [NUM_TAPS*DATA_W-1:0] tap_result;
    logic [DATA_W-1:0]          bias_result;
    logic [DATA_W-1:0]          stage_result;
    logic                       stage_result_vld;
    logic                       out_rdy;

    logic                       data_rd_vld;
    logic [DATA_AW-1:0]         data_rd_addr;
    logic                       data_wr_vld;
    logic [DATA_AW-1:0]         data_wr_addr;
    logic [DATA_W-1:0]          data_wr_data;
    logic                       tap_rd_vld;
    logic [TAP_AW-1:0]          tap_rd_addr;
    logic                       tap_wr_vld;
    logic [TAP_AW-1:0]          tap_wr_addr;
    logic [NUM_TAPS*DATA_W-1:0] tap_wr_data;
    logic                       tap_sub_vld;
    logic [DATA_W-1:0]          tap_sub_addr;
    logic [DATA_W-1:0]          tap_sub_data;
    logic                       bias_rd_vld;
    logic [TAP_AW-1:0]          bias_rd_addr;
    logic                       bias_wr_vld;
    logic [TAP_AW-1:0]          bias_wr_addr;
    logic [DATA_W-1:0]          bias_wr_data;
    logic                       error_rdy;
    logic [DATA_W-1:0]          out_data;
    logic                       out_vld;
    logic                       first;
    logic                       err_overflow;
    logic                       out_overflow;

    modport slave (
        input  active_normal, active_start_d, data_valid, data_value, data_write_addr,
               data_read_addr, tap_address, bias_wr_address, error_update_first,
               error_update_latch, error_phase, error_phase_read, error_valid,
               error_sub_address, error_value, tap_result, bias_result, stage_result,
               stage_result_vld, out_rdy,
        output data_rd_vld, data_rd_addr, data_wr_vld, data_wr_addr, data_wr_data,
               tap_rd_vld, tap_rd_addr, tap_wr_vld, tap_wr_addr, tap_wr_data,
               tap_sub_vld, tap_sub_addr, tap_sub_data, bias_rd_vld, bias_rd_addr,
               bias_wr_vld, bias_wr_addr, bias_wr_data, error_rdy, out_data, out_vld,
               first, err_overflow, out_overflow
    );

    modport master (
        output active_normal, active_start_d, data_valid, data_value, data_write_addr,
               data_read_addr, tap_address, bias_wr_address, error_update_first,
               error_update_latch, error_phase, error_phase_read, error_valid,
               error_sub_address, error_value, tap_result, bias_result, stage_result,
               stage_result_vld, out_rdy,
        input  data_rd_vld, data_rd_addr, data_wr_vld, data_wr_addr, data_wr_data,
               tap_rd_vld, tap_rd_addr, tap_wr_vld, tap_wr_addr, tap_wr_data,
               tap_sub_vld, tap_sub_addr, tap_sub_data, bias_rd_vld, bias_rd_addr,
               bias_wr_vld, bias_wr_addr, bias_wr_data, error_rdy, out_data, out_vld,
               first, err_overflow, out_overflow
    );
endinterface

// File: rtl/full_stage_ctrl_out_ctrl_p.sv
// Output/memory controller for one fully-connected stage: RAM port drive, tap/bias
// feedback write-back delay line, tap write-port arbitration and output skid buffer.
module full_stage_ctrl_out_ctrl_p #(
    parameter int DATA_W   = 32,
    parameter int NUM_TAPS = 6,
    parameter int TAP_AW   = 4,
    parameter int DATA_AW  = 6,
    parameter int PHASE_W  = 2,
    parameter int ERR_BASE = 12,
    parameter int FB_LAT   = 5
) (
    input logic clk,
    input logic reset,
    full_stage_ctrl_out_ctrl_p_if.slave bus
);
    localparam logic [TAP_AW-1:0] ERR_ROW = TAP_AW'(ERR_BASE);

    logic [TAP_AW-1:0] rd_row;

    assign bus.data_wr_vld  = bus.data_valid;
    assign bus.data_wr_addr = bus.data_write_addr;
    assign bus.data_wr_data = bus.data_value;
    assign bus.data_rd_vld  = bus.active_normal;
    assign bus.data_rd_addr = bus.data_read_addr;
    assign bus.first        = bus.active_start_d;

    assign rd_row           = bus.error_update_first ? ERR_ROW + TAP_AW'(bus.error_phase_read)
                                                     : bus.tap_address;
    assign bus.tap_rd_vld   = bus.active_normal;
    assign bus.tap_rd_addr  = rd_row;
    assign bus.bias_rd_vld  = bus.active_normal;
    assign bus.bias_rd_addr = bus.tap_address;

    // Feedback delay line: stage i holds the row read i cycles ago.
    logic [FB_LAT:1]             fb_vld_q, fb_vld_d;
    logic [FB_LAT:1][TAP_AW-1:0] fb_addr_q, fb_addr_d;

    always_comb begin
        fb_vld_d     = fb_vld_q;
        fb_addr_d    = fb_addr_q;
        fb_vld_d[1]  = bus.error_update_latch & ~bus.error_update_first;
        fb_addr_d[1] = rd_row;
        for (int i = 2; i <= FB_LAT; i++) begin
            fb_vld_d[i]  = fb_vld_q[i-1];
            fb_addr_d[i] = fb_addr_q[i-1];
        end
    end

    assign bus.bias_wr_vld  = fb_vld_q[FB_LAT-1];
    assign bus.bias_wr_addr = bus.bias_wr_address;
    assign bus.bias_wr_data = bus.bias_result;

    // Tap write arbitration: feedback row > pending error > fresh error.
    logic               fbt_vld, drain, capture, drop;
    logic               pend_full_q, pend_full_d;
    logic [PHASE_W-1:0] pend_phase_q, pend_phase_d;
    logic [DATA_W-1:0]  pend_sub_q, pend_sub_d, pend_val_q, pend_val_d;
    logic               err_ovf_q, err_ovf_d;

    assign fbt_vld = fb_vld_q[FB_LAT];
    assign drain   = pend_full_q & ~fbt_vld;
    // A refill is allowed in the same cycle the pending entry drains.
    assign capture = bus.error_valid & (fbt_vld ^ pend_full_q);
    assign drop    = bus.error_valid & fbt_vld & pend_full_q;

    always_comb begin
        bus.tap_wr_vld   = 1'b0;
        bus.tap_wr_addr  = '0;
        bus.tap_sub_vld  = 1'b0;
        bus.tap_sub_addr = '0;
        bus.tap_sub_data = '0;
        if (fbt_vld) begin
            bus.tap_wr_vld   = 1'b1;
            bus.tap_wr_addr  = fb_addr_q[FB_LAT];
        end else if (pend_full_q) begin
            bus.tap_wr_vld   = 1'b1;
            bus.tap_wr_addr  = ERR_ROW + TAP_AW'(pend_phase_q);
            bus.tap_sub_vld  = 1'b1;
            bus.tap_sub_addr = pend_sub_q;
            bus.tap_sub_data = pend_val_q;
        end else if (bus.error_valid) begin
            bus.tap_wr_vld   = 1'b1;
            bus.tap_wr_addr  = ERR_ROW + TAP_AW'(bus.error_phase);
            bus.tap_sub_vld  = 1'b1;
            bus.tap_sub_addr = bus.error_sub_address;
            bus.tap_sub_data = bus.error_value;
        end
    end

    assign bus.tap_wr_data  = bus.tap_result;
    assign bus.error_rdy    = ~pend_full_q | drain;
    assign bus.err_overflow = err_ovf_q;

    always_comb begin
        pend_full_d  = capture | (pend_full_q & ~drain);
        pend_phase_d = capture ? bus.error_phase       : pend_phase_q;
        pend_sub_d   = capture ? bus.error_sub_address : pend_sub_q;
        pend_val_d   = capture ? bus.error_value       : pend_val_q;
        err_ovf_d    = err_ovf_q | drop;
    end

    // Output skid buffer, 2 entries.
    logic [1:0][DATA_W-1:0] mem_q, mem_d;
    logic                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   out_ovf_q, out_ovf_d;
    logic                   push, pop, full;

    assign full = (cnt_q == 2'd2);
    assign pop  = (cnt_q != 2'd0) & bus.out_rdy;
    assign push = bus.stage_result_vld & (~full | pop);

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = bus.stage_result;
        wr_ptr_d  = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d  = pop  ? ~rd_ptr_q : rd_ptr_q;
        cnt_d     = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        out_ovf_d = out_ovf_q | (bus.stage_result_vld & full & ~pop);
    end

    assign bus.out_vld      = (cnt_q != 2'd0);
    assign bus.out_data     = mem_q[rd_ptr_q];
    assign bus.out_overflow = out_ovf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb_vld_q     <= '0;
            fb_addr_q    <= '0;
            pend_full_q  <= 1'b0;
            pend_phase_q <= '0;
            pend_sub_q   <= '0;
            pend_val_q   <= '0;
            err_ovf_q    <= 1'b0;
            mem_q        <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= '0;
            out_ovf_q    <= 1'b0;
        end else begin
            fb_vld_q     <= fb_vld_d;
            fb_addr_q    <= fb_addr_d;
            pend_full_q  <= pend_full_d;
            pend_phase_q <= pend_phase_d;
            pend_sub_q   <= pend_sub_d;
            pend_val_q   <= pend_val_d;
            err_ovf_q    <= err_ovf_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            out_ovf_q    <= out_ovf_d;
        end
    end
endmodule

// File: tb/tb_full_stage_ctrl_out_ctrl_p.sv
module tb_full_stage_ctrl_out_ctrl_p;
  localparam int DATA_W = 32, NUM_TAPS = 6, TAP_AW = 4, DATA_AW = 6, PHASE_W = 2;
  localparam int CW = NUM_TAPS*DATA_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  full_stage_ctrl_out_ctrl_p_if #(.DATA_W(DATA_W), .NUM_TAPS(NUM_TAPS), .TAP_AW(TAP_AW),
    .DATA_AW(DATA_AW), .PHASE_W(PHASE_W)) bus ();

  full_stage_ctrl_out_ctrl_p #(.DATA_W(DATA_W), .NUM_TAPS(NUM_TAPS), .TAP_AW(TAP_AW),
    .DATA_AW(DATA_AW), .PHASE_W(PHASE_W), .ERR_BASE(12), .FB_LAT(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.active_normal = 1'b0;      bus.active_start_d = 1'b0;
    bus.data_valid = 1'b0;         bus.data_value = '0;
    bus.data_write_addr = '0;      bus.data_read_addr = '0;
    bus.tap_address = '0;          bus.bias_wr_address = '0;
    bus.error_update_first = 1'b0; bus.error_update_latch = 1'b0;
    bus.error_phase = '0;          bus.error_phase_read = '0;
    bus.error_valid = 1'b0;        bus.error_sub_address = '0;
    bus.error_value = '0;          bus.tap_result = '0;
    bus.bias_result = '0;          bus.stage_result = '0;
    bus.stage_result_vld = 1'b0;   bus.out_rdy = 1'b0;

    tick; tick;
    chk("rst_tap_wr_vld", bus.tap_wr_vld, 1'b0);
    chk("rst_bias_wr_vld", bus.bias_wr_vld, 1'b0);
    chk("rst_out_vld", bus.out_vld, 1'b0);
    chk("rst_err_ovf", bus.err_overflow, 1'b0);
    chk("rst_out_ovf", bus.out_overflow, 1'b0);
    chk("rst_error_rdy", bus.error_rdy, 1'b1);
    reset = 1'b1;
    tick;

    bus.active_normal = 1'b1; bus.active_start_d = 1'b1;
    bus.data_valid = 1'b1; bus.data_write_addr = 6'd33; bus.data_value = 32'hCAFE0001;
    bus.data_read_addr = 6'd17; bus.tap_result = {6{32'h0000ABCD}};
    #1;
    chk("data_wr_vld", bus.data_wr_vld, 1'b1);
    chk("data_wr_addr", bus.data_wr_addr, 6'd33);
    chk("data_wr_data", bus.data_wr_data, 32'hCAFE0001);
    chk("data_rd_addr", bus.data_rd_addr, 6'd17);
    chk("first", bus.first, 1'b1);
    chk("tap_wr_data", bus.tap_wr_data, {6{32'h0000ABCD}});
    bus.data_valid = 1'b0; bus.active_start_d = 1'b0;

    bus.tap_address = 4'd3; bus.bias_wr_address = 4'd9; bus.bias_result = 32'h0B1A5;
    bus.error_update_latch = 1'b1;
    #1;
    chk("t1_tap_rd_addr", bus.tap_rd_addr, 4'd3);
    chk("t1_bias_rd_addr", bus.bias_rd_addr, 4'd3);
    chk("t1_tap_rd_vld", bus.tap_rd_vld, 1'b1);
    tick;
    bus.error_update_latch = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      chk("t1_bias_wr_vld", bus.bias_wr_vld, (c == 4));
      chk("t1_tap_wr_vld", bus.tap_wr_vld, (c == 5));
      if (c == 4) begin
        chk("t1_bias_wr_addr", bus.bias_wr_addr, 4'd9);
        chk("t1_bias_wr_data", bus.bias_wr_data, 32'h0B1A5);
      end
      if (c == 5) begin
        chk("t1_tap_wr_addr", bus.tap_wr_addr, 4'd3);
        chk("t1_sub_vld", bus.tap_sub_vld, 1'b0);
      end
      tick;
    end

    bus.error_update_first = 1'b1; bus.error_phase_read = 2'd2;
    #1;
    chk("t2_tap_rd_addr", bus.tap_rd_addr, 4'd14);
    bus.error_update_first = 1'b0;
    bus.error_valid = 1'b1; bus.error_phase = 2'd1;
    bus.error_sub_address = 32'd5; bus.error_value = 32'hDEAD;
    #1;
    chk("t2_tap_wr_vld", bus.tap_wr_vld, 1'b1);
    chk("t2_tap_wr_addr", bus.tap_wr_addr, 4'd13);
    chk("t2_sub_vld", bus.tap_sub_vld, 1'b1);
    chk("t2_sub_addr", bus.tap_sub_addr, 32'd5);
    chk("t2_sub_data", bus.tap_sub_data, 32'hDEAD);
    chk("t2_error_rdy", bus.error_rdy, 1'b1);
    tick;
    bus.error_valid = 1'b0;
    #1;
    chk("t2_no_pending", bus.tap_wr_vld, 1'b0);

    bus.tap_address = 4'd7; bus.error_update_latch = 1'b1;
    tick;
    bus.error_update_latch = 1'b0;
    tick; tick; tick; tick;
    bus.error_valid = 1'b1; bus.error_phase = 2'd2;
    bus.error_sub_address = 32'd3; bus.error_value = 32'hBEEF;
    #1;
    chk("t3_fb_addr", bus.tap_wr_addr, 4'd7);
    chk("t3_fb_sub_vld", bus.tap_sub_vld, 1'b0);
    chk("t3_rdy_a", bus.error_rdy, 1'b1);
    tick;
    bus.error_valid = 1'b0;
    #1;
    chk("t3_pend_vld", bus.tap_wr_vld, 1'b1);
    chk("t3_pend_addr", bus.tap_wr_addr, 4'd14);
    chk("t3_pend_sub_addr", bus.tap_sub_addr, 32'd3);
    chk("t3_pend_sub_data", bus.tap_sub_data, 32'hBEEF);
    chk("t3_rdy_b", bus.error_rdy, 1'b1);
    tick;
    chk("t3_idle", bus.tap_wr_vld, 1'b0);

    bus.error_update_latch = 1'b1; bus.tap_address = 4'd1;
    tick;
    bus.tap_address = 4'd2;
    tick;
    bus.tap_address = 4'd4;
    tick;
    bus.error_update_latch = 1'b0;
    tick; tick;
    bus.error_valid = 1'b1; bus.error_phase = 2'd0;
    bus.error_sub_address = 32'd1; bus.error_value = 32'h111;
    #1;
    chk("t4_a_addr", bus.tap_wr_addr, 4'd1);
    chk("t4_a_rdy", bus.error_rdy, 1'b1);
    tick;
    bus.error_phase = 2'd1; bus.error_value = 32'h222;
    #1;
    chk("t4_b_addr", bus.tap_wr_addr, 4'd2);
    chk("t4_b_rdy", bus.error_rdy, 1'b0);
    chk("t4_b_ovf", bus.err_overflow, 1'b0);
    tick;
    bus.error_phase = 2'd3; bus.error_value = 32'h333;
    #1;
    chk("t4_c_addr", bus.tap_wr_addr, 4'd4);
    chk("t4_c_rdy", bus.error_rdy, 1'b0);
    chk("t4_c_ovf", bus.err_overflow, 1'b1);
    tick;
    bus.error_valid = 1'b0;
    #1;
    chk("t4_drain_addr", bus.tap_wr_addr, 4'd12);
    chk("t4_drain_data", bus.tap_sub_data, 32'h111);
    chk("t4_drain_sub", bus.tap_sub_vld, 1'b1);
    tick;
    chk("t4_idle", bus.tap_wr_vld, 1'b0);
    chk("t4_ovf_sticky", bus.err_overflow, 1'b1);

    bus.out_rdy = 1'b0;
    bus.stage_result_vld = 1'b1; bus.stage_result = 32'hA;
    tick;
    chk("t5_latency_vld", bus.out_vld, 1'b1);
    chk("t5_latency_data", bus.out_data, 32'hA);
    bus.stage_result = 32'hB;
    tick;
    bus.stage_result = 32'hC;
    tick;
    bus.stage_result_vld = 1'b0;
    chk("t5_out_ovf", bus.out_overflow, 1'b1);
    chk("t5_hold_vld", bus.out_vld, 1'b1);
    chk("t5_hold_data", bus.out_data, 32'hA);
    bus.out_rdy = 1'b1;
    tick;
    chk("t5_b_vld", bus.out_vld, 1'b1);
    chk("t5_b_data", bus.out_data, 32'hB);
    tick;
    chk("t5_empty", bus.out_vld, 1'b0);

    bus.out_rdy = 1'b0;
    bus.stage_result_vld = 1'b1; bus.stage_result = 32'hD;
    tick;
    bus.stage_result = 32'hE;
    tick;
    bus.out_rdy = 1'b1; bus.stage_result = 32'hF;
    tick;
    bus.stage_result_vld = 1'b0;
    chk("t5_pp_e", bus.out_data, 32'hE);
    tick;
    chk("t5_pp_f_vld", bus.out_vld, 1'b1);
    chk("t5_pp_f", bus.out_data, 32'hF);
    tick;
    chk("t5_pp_empty", bus.out_vld, 1'b0);

    bus.out_rdy = 1'b0; bus.active_normal = 1'b0;
    bus.tap_address = 4'd5; bus.error_update_latch = 1'b1;
    bus.stage_result_vld = 1'b1; bus.stage_result = 32'h6;
    tick;
    bus.error_update_latch = 1'b0; bus.stage_result_vld = 1'b0;
    tick;
    chk("t6_pre_out_vld", bus.out_vld, 1'b1);
    reset = 1'b0;
    #1;
    chk("t6_out_vld", bus.out_vld, 1'b0);
    chk("t6_tap_wr_vld", bus.tap_wr_vld, 1'b0);
    chk("t6_bias_wr_vld", bus.bias_wr_vld, 1'b0);
    chk("t6_err_ovf", bus.err_overflow, 1'b0);
    chk("t6_out_ovf", bus.out_overflow, 1'b0);
    chk("t6_rd_vld", bus.tap_rd_vld, 1'b0);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick;
      chk("t6_post_tap_wr", bus.tap_wr_vld, 1'b0);
      chk("t6_post_bias_wr", bus.bias_wr_vld, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
